// File: rtl/fifo_rd_ctrl_pkg.sv
// Shared definitions for the async-FIFO read-side controller.
// Holds default geometry and the Gray-to-binary helper.
package fifo_rd_ctrl_pkg;

  localparam int DEF_ADDR_WIDTH = 4;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_AE_THRESH  = 2;

  // Width-generic decode: callers zero-extend into 32 bits and cast the result back
  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b[31] = g[31];
    for (int i = 30; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/fifo_rd_if.sv
// Read-side FIFO bus: pointer exchange, memory read port and consumer handshake.
// The master modport is the read controller; the slave modport is its environment.
interface fifo_rd_if #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8
);

  logic [ADDR_WIDTH:0]   rq2_wptr;
  logic [ADDR_WIDTH:0]   rptr;
  logic [ADDR_WIDTH-1:0] raddr;
  logic                  ren;
  logic [DATA_WIDTH-1:0] rdata_mem;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_valid;
  logic                  out_ready;
  logic                  rempty;
  logic                  ralmost_empty;
  logic [ADDR_WIDTH:0]   rlevel;

  modport master (
    input  rq2_wptr, rdata_mem, out_ready,
    output rptr, raddr, ren, out_data, out_valid, rempty, ralmost_empty, rlevel
  );

  modport slave (
    output rq2_wptr, rdata_mem, out_ready,
    input  rptr, raddr, ren, out_data, out_valid, rempty, ralmost_empty, rlevel
  );

endinterface

// File: rtl/fifo_rd_skid.sv
// Two-entry output buffer absorbing the one-cycle memory read latency.
// Entry 0 is always the head; a write and pop in the same cycle keep occupancy.
module fifo_rd_skid #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  output logic [1:0]            occ
);

  logic [DATA_WIDTH-1:0] e0_r;
  logic [DATA_WIDTH-1:0] e1_r;
  logic [1:0]            occ_r;
  logic                  pop_s;

  // Pop is only meaningful when the head entry holds a word
  always_comb begin
    pop_s = 1'b0;
    if (occ_r != 2'd0) begin
      pop_s = rd_ready;
    end else begin
      pop_s = 1'b0;
    end
  end

  // Buffer storage and occupancy update
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      e0_r  <= '0;
      e1_r  <= '0;
      occ_r <= 2'd0;
    end else begin
      case ({wr_en, pop_s})
        2'b10: begin
          if (occ_r == 2'd0) begin
            e0_r  <= wr_data;
            occ_r <= 2'd1;
          end else if (occ_r == 2'd1) begin
            e1_r  <= wr_data;
            occ_r <= 2'd2;
          end
        end
        2'b01: begin
          e0_r  <= e1_r;
          occ_r <= occ_r - 2'd1;
        end
        2'b11: begin
          if (occ_r == 2'd1) begin
            e0_r <= wr_data;
          end else begin
            e0_r <= e1_r;
            e1_r <= wr_data;
          end
        end
        default: begin
          occ_r <= occ_r;
        end
      endcase
    end
  end

  assign out_data  = e0_r;
  assign out_valid = (occ_r != 2'd0);
  assign occ       = occ_r;

endmodule

// File: rtl/fifo_rd_ctrl.sv
// Async-FIFO read-side controller: Gray read pointer, empty/level flags and
// prefetch into a two-entry output buffer so the consumer sees one word per cycle.
module fifo_rd_ctrl
  import fifo_rd_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int AE_THRESH  = DEF_AE_THRESH
) (
  input logic      rclk,
  input logic      rrst_n,
  fifo_rd_if.master bus
);

  localparam int PW = ADDR_WIDTH + 1;
  localparam logic [PW-1:0] AE_LVL = PW'(AE_THRESH);

  logic [PW-1:0]         rbin_r;
  logic [PW-1:0]         rptr_r;
  logic [PW-1:0]         rlevel_r;
  logic                  rempty_r;
  logic                  ralmost_empty_r;
  logic                  inflight_r;
  logic [PW-1:0]         rbin_next_s;
  logic [PW-1:0]         gray_next_s;
  logic [PW-1:0]         wbin_s;
  logic [PW-1:0]         level_next_s;
  logic                  ren_s;
  logic                  pop_s;
  logic [2:0]            pending_s;
  logic [1:0]            occ_s;
  logic                  out_valid_s;
  logic [DATA_WIDTH-1:0] out_data_s;

  // Fetch when memory has data and the buffer has room once in-flight data lands
  always_comb begin
    pop_s     = out_valid_s & bus.out_ready;
    pending_s = {1'b0, occ_s} + {2'b00, inflight_r};
    if (!rrst_n) begin
      ren_s = 1'b0;
    end else if (rempty_r) begin
      ren_s = 1'b0;
    end else if ((pending_s < 3'd2) || pop_s) begin
      ren_s = 1'b1;
    end else begin
      ren_s = 1'b0;
    end
  end

  // Next pointer, its Gray form, and the unfetched word count it implies
  always_comb begin
    rbin_next_s  = rbin_r + {{ADDR_WIDTH{1'b0}}, ren_s};
    gray_next_s  = rbin_next_s ^ (rbin_next_s >> 1'b1);
    wbin_s       = PW'(gray2bin(32'(bus.rq2_wptr)));
    level_next_s = wbin_s - rbin_next_s;
  end

  // Pointer, flag and level registers
  always_ff @(posedge rclk) begin
    if (!rrst_n) begin
      rbin_r          <= '0;
      rptr_r          <= '0;
      rlevel_r        <= '0;
      rempty_r        <= 1'b1;
      ralmost_empty_r <= 1'b1;
      inflight_r      <= 1'b0;
    end else begin
      rbin_r          <= rbin_next_s;
      rptr_r          <= gray_next_s;
      rlevel_r        <= level_next_s;
      rempty_r        <= (gray_next_s == bus.rq2_wptr);
      ralmost_empty_r <= (level_next_s <= AE_LVL);
      inflight_r      <= ren_s;
    end
  end

  fifo_rd_skid #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_skid (
    .clk       (rclk),
    .rst_n     (rrst_n),
    .wr_en     (inflight_r),
    .wr_data   (bus.rdata_mem),
    .rd_ready  (bus.out_ready),
    .out_data  (out_data_s),
    .out_valid (out_valid_s),
    .occ       (occ_s)
  );

  assign bus.rptr          = rptr_r;
  assign bus.raddr         = rbin_r[ADDR_WIDTH-1:0];
  assign bus.ren           = ren_s;
  assign bus.out_data      = out_data_s;
  assign bus.out_valid     = out_valid_s;
  assign bus.rempty        = rempty_r;
  assign bus.ralmost_empty = ralmost_empty_r;
  assign bus.rlevel        = rlevel_r;

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Directed bench for fifo_rd_ctrl: a behavioural memory stands in for the
// write side; each scenario task carries its own hand-derived expectations.
module tb_fifo_rd_ctrl;

  logic rclk;
  logic rrst_n;
  int   checks;
  int   failures;
  logic [7:0] mem [16];

  fifo_rd_if #(.ADDR_WIDTH(4), .DATA_WIDTH(8)) bus ();

  fifo_rd_ctrl #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .AE_THRESH(2)) dut (
    .rclk   (rclk),
    .rrst_n (rrst_n),
    .bus    (bus)
  );

  initial rclk = 1'b0;
  always #5 rclk = ~rclk;

  // Synchronous memory: data appears one cycle after ren
  always @(posedge rclk) begin
    if (bus.ren) bus.rdata_mem <= mem[bus.raddr];
  end

  function automatic logic [4:0] g(input int b);
    logic [4:0] v;
    v = 5'(b);
    return v ^ (v >> 1);
  endfunction

  task automatic tick();
    @(posedge rclk);
    #1;
  endtask

  task automatic reset_dut();
    rrst_n = 1'b0;
    bus.rq2_wptr = 5'd0;
    bus.out_ready = 1'b0;
    tick();
    tick();
    rrst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rrst_n = 1'b0;
    bus.rq2_wptr = 5'd0;
    bus.out_ready = 1'b0;
    tick();
    tick();
    checks++;
    if (bus.ren !== 1'b0) begin failures++; $display("FAIL reset_ren_held got=%b exp=0", bus.ren); end
    rrst_n = 1'b1;
    tick();
    checks++;
    if (bus.rempty !== 1'b1) begin failures++; $display("FAIL reset_rempty got=%b exp=1", bus.rempty); end
    checks++;
    if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
    checks++;
    if (bus.ren !== 1'b0) begin failures++; $display("FAIL reset_ren got=%b exp=0", bus.ren); end
    checks++;
    if (bus.rptr !== 5'd0) begin failures++; $display("FAIL reset_rptr got=%h exp=0", bus.rptr); end
    checks++;
    if (bus.rlevel !== 5'd0) begin failures++; $display("FAIL reset_rlevel got=%0d exp=0", bus.rlevel); end
    checks++;
    if (bus.ralmost_empty !== 1'b1) begin failures++; $display("FAIL reset_almost_empty got=%b exp=1", bus.ralmost_empty); end
    checks++;
    if (bus.out_data !== 8'h00) begin failures++; $display("FAIL reset_out_data got=%h exp=00", bus.out_data); end
  endtask

  task automatic test_single_word();
    int rens;
    reset_dut();
    mem[0] = 8'hA5;
    bus.out_ready = 1'b1;
    bus.rq2_wptr = g(1);
    rens = 0;
    tick();
    checks++;
    if (bus.rempty !== 1'b0) begin failures++; $display("FAIL single_rempty_fall got=%b exp=0", bus.rempty); end
    checks++;
    if (bus.rlevel !== 5'd1) begin failures++; $display("FAIL single_rlevel got=%0d exp=1", bus.rlevel); end
    rens += int'(bus.ren);
    tick();
    rens += int'(bus.ren);
    checks++;
    if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL single_early_valid got=%b exp=0", bus.out_valid); end
    tick();
    rens += int'(bus.ren);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 8'hA5) begin
      failures++; $display("FAIL single_data got=%b/%h exp=1/a5", bus.out_valid, bus.out_data);
    end
    tick();
    rens += int'(bus.ren);
    checks++;
    if (rens != 1) begin failures++; $display("FAIL single_ren_count got=%0d exp=1", rens); end
    checks++;
    if (bus.rempty !== 1'b1 || bus.rptr !== 5'b00001) begin
      failures++; $display("FAIL single_after got=%b/%b exp=1/00001", bus.rempty, bus.rptr);
    end
    checks++;
    if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL single_dup got=%b exp=0", bus.out_valid); end
  endtask

  task automatic test_burst_stall();
    int rens;
    int got;
    int cyc [8];
    reset_dut();
    for (int i = 0; i < 8; i++) mem[i] = 8'h10 + 8'(i);
    bus.rq2_wptr = g(8);
    rens = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      rens += int'(bus.ren);
    end
    checks++;
    if (rens != 2) begin failures++; $display("FAIL burst_stall_reads got=%0d exp=2", rens); end
    bus.out_ready = 1'b1;
    got = 0;
    for (int c = 0; c < 40 && got < 8; c++) begin
      if (bus.out_valid) begin
        checks++;
        if (bus.out_data !== 8'h10 + 8'(got)) begin
          failures++; $display("FAIL burst_word%0d got=%h exp=%h", got, bus.out_data, 8'h10 + 8'(got));
        end
        cyc[got] = c;
        got++;
      end
      tick();
    end
    checks++;
    if (got != 8) begin failures++; $display("FAIL burst_count got=%0d exp=8", got); end
    for (int k = 3; k < 8; k++) begin
      checks++;
      if (k < got && cyc[k] - cyc[k-1] != 1) begin
        failures++; $display("FAIL burst_gap%0d got=%0d exp=1", k, cyc[k] - cyc[k-1]);
      end
    end
    tick();
    checks++;
    if (bus.out_valid !== 1'b0 || bus.rempty !== 1'b1) begin
      failures++; $display("FAIL burst_tail got=%b/%b exp=0/1", bus.out_valid, bus.rempty);
    end
  endtask

  task automatic test_wrap();
    int written;
    int consumed;
    int c;
    logic [4:0] prev;
    logic [4:0] diff;
    reset_dut();
    written = 0;
    consumed = 0;
    prev = bus.rptr;
    c = 0;
    while (consumed < 40 && c < 600) begin
      bus.out_ready = 1'($urandom_range(0, 1));
      if (written < 40 && written - consumed < 16) begin
        mem[written % 16] = 8'(written * 7 + 3);
        written++;
        bus.rq2_wptr = g(written);
      end
      #1;
      checks++;
      if (bus.ren && bus.rempty) begin failures++; $display("FAIL wrap_underflow got=1 exp=0"); end
      if (bus.out_valid && bus.out_ready) begin
        checks++;
        if (bus.out_data !== 8'(consumed * 7 + 3)) begin
          failures++; $display("FAIL wrap_word%0d got=%h exp=%h", consumed, bus.out_data, 8'(consumed * 7 + 3));
        end
        consumed++;
      end
      tick();
      c++;
      if (bus.rptr !== prev) begin
        diff = bus.rptr ^ prev;
        checks++;
        if ($countones(diff) != 1) begin
          failures++; $display("FAIL wrap_gray_step got=%b exp_onehot_from=%b", bus.rptr, prev);
        end
        prev = bus.rptr;
      end
    end
    checks++;
    if (consumed != 40) begin failures++; $display("FAIL wrap_timeout got=%0d exp=40", consumed); end
    bus.out_ready = 1'b0;
    checks++;
    if (bus.rptr !== 5'b01100 || bus.rempty !== 1'b1) begin
      failures++; $display("FAIL wrap_final_rptr got=%b/%b exp=01100/1", bus.rptr, bus.rempty);
    end
  endtask

  task automatic test_level();
    reset_dut();
    for (int i = 0; i < 5; i++) mem[i] = 8'hC0 + 8'(i);
    bus.rq2_wptr = g(5);
    for (int i = 0; i < 6; i++) begin
      tick();
      if (i >= 3) begin
        checks++;
        if (bus.out_data !== 8'hC0) begin failures++; $display("FAIL level_stable got=%h exp=c0", bus.out_data); end
      end
    end
    checks++;
    if (bus.rlevel !== 5'd3) begin failures++; $display("FAIL level_prefetch got=%0d exp=3", bus.rlevel); end
    checks++;
    if (bus.ralmost_empty !== 1'b0) begin failures++; $display("FAIL level_ae_low got=%b exp=0", bus.ralmost_empty); end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    checks++;
    if (bus.rlevel !== 5'd2) begin failures++; $display("FAIL level_after_pop got=%0d exp=2", bus.rlevel); end
    checks++;
    if (bus.ralmost_empty !== 1'b1) begin failures++; $display("FAIL level_ae_high got=%b exp=1", bus.ralmost_empty); end
    checks++;
    if (bus.out_data !== 8'hC1) begin failures++; $display("FAIL level_next_head got=%h exp=c1", bus.out_data); end
  endtask

  task automatic test_reset_mid_burst();
    reset_dut();
    for (int i = 0; i < 6; i++) mem[i] = 8'h30 + 8'(i);
    bus.rq2_wptr = g(6);
    for (int i = 0; i < 5; i++) tick();
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h30) begin
      failures++; $display("FAIL midrst_pre got=%b/%h exp=1/30", bus.out_valid, bus.out_data);
    end
    rrst_n = 1'b0;
    tick();
    checks++;
    if (bus.rptr !== 5'd0 || bus.rlevel !== 5'd0 || bus.rempty !== 1'b1 || bus.ralmost_empty !== 1'b1) begin
      failures++; $display("FAIL midrst_flags got=%b/%0d/%b/%b exp=00000/0/1/1", bus.rptr, bus.rlevel, bus.rempty, bus.ralmost_empty);
    end
    checks++;
    if (bus.out_valid !== 1'b0 || bus.out_data !== 8'h00 || bus.ren !== 1'b0) begin
      failures++; $display("FAIL midrst_out got=%b/%h/%b exp=0/00/0", bus.out_valid, bus.out_data, bus.ren);
    end
    bus.rq2_wptr = 5'd0;
    bus.out_ready = 1'b1;
    rrst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL midrst_leak got=%b exp=0", bus.out_valid); end
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rrst_n = 1'b0;
    bus.rq2_wptr = 5'd0;
    bus.out_ready = 1'b0;
    test_reset();
    test_single_word();
    test_burst_stall();
    test_wrap();
    test_level();
    test_reset_mid_burst();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
